// File: rtl/peripheral_syn_pkg.sv
// Shared types and constants for the commit-record synchronisation queue.
// Records carry one retired instruction: {instrcnt, pc, rfdata}.
package peripheral_syn_pkg;

    localparam int unsigned SYN_XLEN    = 64;
    localparam int unsigned SYN_REC_W   = 3 * SYN_XLEN;
    localparam logic [31:0] DROP_CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [SYN_XLEN-1:0] instrcnt;
        logic [SYN_XLEN-1:0] pc;
        logic [SYN_XLEN-1:0] rfdata;
    } syn_rec_t;

    // Stored bits per record for an arbitrary XLEN.
    function automatic int unsigned syn_rec_width(input int unsigned xlen);
        return 3 * xlen;
    endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// Record storage for the commit queue: one synchronous write port and an
// asynchronous read port so the head record falls through with no latency.
module syn_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 192
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and
    // level in the parent, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/peripheral_syn_queue.sv
// First-word-fall-through queue of retired-instruction commit records, with
// optional rfwen filtering, sticky overflow and a saturating drop counter.
module peripheral_syn_queue
    import peripheral_syn_pkg::*;
#(
    parameter int unsigned XLEN       = SYN_XLEN,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WEN_FILTER = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [XLEN-1:0]            s_pc,
    input  logic [XLEN-1:0]            s_instrcnt,
    input  logic [XLEN-1:0]            s_rfdata,
    input  logic                       s_rfwen,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [2*XLEN-1:0]          m_syn_reg1,
    output logic [2*XLEN-1:0]          m_syn_reg2,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [31:0]                drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned RW = syn_rec_width(XLEN);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("peripheral_syn_queue: DEPTH must be a power of two in 2..64");
    end

    typedef struct packed {
        logic [XLEN-1:0] instrcnt;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rfdata;
    } rec_t;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   drop_q, drop_d;

    logic wen_pass;
    logic push;
    logic pop;
    logic drop;
    rec_t wr_rec;
    rec_t rd_rec;

    // Readiness comes from registered level only, so a pop in the same cycle
    // never opens room for a push.
    assign s_ready  = (level_q != LVL_FULL);
    assign m_valid  = (level_q != '0);
    assign wen_pass = !((WEN_FILTER != 0) && !s_rfwen);
    assign push     = s_valid && s_ready && wen_pass;
    assign pop      = m_valid && m_ready;
    assign drop     = s_valid && !s_ready && wen_pass;

    assign wr_rec = '{instrcnt: s_instrcnt,
                      pc:       s_pc,
                      rfdata:   s_rfwen ? s_rfdata : '0};

    syn_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push && !flush),
        .waddr_i (wptr_q),
        .wdata_i (wr_rec),
        .raddr_i (rptr_q),
        .rdata_o (rd_rec)
    );

    // NOTE: every next-state value gets a default first, so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != DROP_CNT_MAX) begin
                    drop_d = drop_q + 32'd1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset here is synchronous to match the host system.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Head fields are masked while empty so stale array contents never leak.
    assign m_syn_reg1 = m_valid ? {rd_rec.instrcnt, rd_rec.pc} : '0;
    assign m_syn_reg2 = m_valid ? {{XLEN{1'b0}}, rd_rec.rfdata} : '0;
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_peripheral_syn_queue.sv
// Scoreboard bench: a queue model of expected records is updated as stimulus
// is driven, and the DUT head is compared against its front every cycle.
module tb_peripheral_syn_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              resetn;

    logic              s_valid, s_ready, s_rfwen, flush, m_valid, m_ready, overflow;
    logic [XLEN-1:0]   s_pc, s_instrcnt, s_rfdata;
    logic [2*XLEN-1:0] m_syn_reg1, m_syn_reg2;
    logic [LW-1:0]     level;
    logic [31:0]       drop_cnt;

    logic              f_s_valid, f_s_ready, f_s_rfwen, f_flush, f_m_valid, f_m_ready, f_overflow;
    logic [XLEN-1:0]   f_s_pc, f_s_instrcnt, f_s_rfdata;
    logic [2*XLEN-1:0] f_m_syn_reg1, f_m_syn_reg2;
    logic [LW-1:0]     f_level;
    logic [31:0]       f_drop_cnt;

    peripheral_syn_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .WEN_FILTER(0)) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_pc(s_pc), .s_instrcnt(s_instrcnt), .s_rfdata(s_rfdata), .s_rfwen(s_rfwen),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_syn_reg1(m_syn_reg1), .m_syn_reg2(m_syn_reg2),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    peripheral_syn_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .WEN_FILTER(1)) dut_f (
        .clk(clk), .resetn(resetn), .s_valid(f_s_valid), .s_ready(f_s_ready),
        .s_pc(f_s_pc), .s_instrcnt(f_s_instrcnt), .s_rfdata(f_s_rfdata), .s_rfwen(f_s_rfwen),
        .flush(f_flush), .m_valid(f_m_valid), .m_ready(f_m_ready),
        .m_syn_reg1(f_m_syn_reg1), .m_syn_reg2(f_m_syn_reg2),
        .level(f_level), .overflow(f_overflow), .drop_cnt(f_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ic;
        logic [XLEN-1:0] rd;
    } rec_t;

    rec_t        sb[$];
    bit          m_ovf;
    logic [31:0] m_drop;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_head();
        if (sb.size() != 0) begin
            check("m_valid_head", m_valid, 1'b1);
            check("head_reg1", m_syn_reg1, {sb[0].ic, sb[0].pc});
            check("head_reg2", m_syn_reg2, {64'h0, sb[0].rd});
        end else begin
            check("m_valid_empty", m_valid, 1'b0);
            check("reg1_empty", m_syn_reg1, '0);
            check("reg2_empty", m_syn_reg2, '0);
        end
    endtask

    task automatic check_state();
        check("level", level, sb.size());
        check("s_ready", s_ready, sb.size() != DEPTH);
        check("m_valid", m_valid, sb.size() != 0);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    // Called at a falling edge; drives one cycle and updates the model.
    task automatic step(input bit v, input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                        input logic [XLEN-1:0] d, input bit wen, input bit rdy, input bit fl);
        int sz;
        s_valid = v; s_pc = p; s_instrcnt = i; s_rfdata = d; s_rfwen = wen;
        m_ready = rdy; flush = fl;
        check_head();
        sz = sb.size();
        if (fl) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_drop = '0;
        end else begin
            if (v && sz == DEPTH) begin
                m_ovf = 1'b1;
                if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            end
            if (rdy && sz != 0) void'(sb.pop_front());
            if (v && sz != DEPTH) sb.push_back('{pc: p, ic: i, rd: (wen ? d : '0)});
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
        check_state();
    endtask

    task automatic f_step(input bit v, input logic [XLEN-1:0] i, input bit wen, input bit rdy);
        f_s_valid = v; f_s_instrcnt = i; f_s_pc = i << 4; f_s_rfdata = i + 64'h100;
        f_s_rfwen = wen; f_m_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        f_s_valid = 1'b0; f_m_ready = 1'b0;
    endtask

    // Reset with busy inputs to show reset wins over them.
    task automatic do_reset();
        resetn = 1'b0;
        s_valid = 1'b1; m_ready = 1'b1; s_rfwen = 1'b1; f_s_valid = 1'b1; f_m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        s_valid = 1'b0; m_ready = 1'b0; f_s_valid = 1'b0; f_m_ready = 1'b0;
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = '0;
        check_state();
        check_head();
        check("f_level_rst", f_level, 0);
        check("f_ready_rst", f_s_ready, 1'b1);
    endtask

    initial begin
        checks = 0; errors = 0;
        resetn = 1'b0;
        s_valid = 0; s_pc = '0; s_instrcnt = '0; s_rfdata = '0; s_rfwen = 0; flush = 0; m_ready = 0;
        f_s_valid = 0; f_s_pc = '0; f_s_instrcnt = '0; f_s_rfdata = '0; f_s_rfwen = 0;
        f_flush = 0; f_m_ready = 0;
        m_ovf = 0; m_drop = '0;
        @(negedge clk);
        do_reset();

        // Single record into an empty queue.
        step(1, 64'h8000_0000, 64'h1, 64'hDEAD, 1, 0, 0);
        check("single_valid", m_valid, 1'b1);
        check("single_reg1", m_syn_reg1, {64'h1, 64'h8000_0000});
        check("single_reg2", m_syn_reg2, {64'h0, 64'hDEAD});
        step(0, '0, '0, '0, 0, 1, 0);

        // Fill past full with the host stalled, then drain in order.
        for (int i = 1; i <= 10; i++)
            step(1, 64'h1000 + 64'(i * 4), 64'(i), 64'(i * 3), 1, 0, 0);
        check("fill_level", level, 8);
        check("fill_ready", s_ready, 1'b0);
        check("fill_ovf", overflow, 1'b1);
        check("fill_drops", drop_cnt, 2);
        for (int i = 1; i <= 8; i++) begin
            check("drain_ic", m_syn_reg1[2*XLEN-1:XLEN], i);
            step(0, '0, '0, '0, 0, 1, 0);
        end
        check("drained_level", level, 0);

        // Steady push+pop at level 3; pointers wrap several times.
        for (int i = 0; i < 3; i++)
            step(1, 64'h2000 + 64'(i), 64'(100 + i), 64'(i), 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 64'h3000 + 64'(i), 64'(200 + i), 64'(i + 7), 1, 1, 0);
            check("conc_level", level, 3);
        end

        // Flush beats a same-cycle push and pop at level 5 with overflow set.
        step(1, 64'h4000, 64'd300, 64'h1, 1, 0, 0);
        step(1, 64'h4004, 64'd301, 64'h2, 1, 0, 0);
        check("preflush_level", level, 5);
        check("preflush_ovf", overflow, 1'b1);
        step(1, 64'h4008, 64'd302, 64'h3, 1, 1, 1);
        check("flush_level", level, 0);
        check("flush_valid", m_valid, 1'b0);
        check("flush_ovf", overflow, 1'b0);
        check("flush_drops", drop_cnt, 0);

        // rfwen=0 without filtering: queued, rfdata forced to zero.
        step(1, 64'h40, 64'h7, 64'h1234, 0, 0, 0);
        check("nowen_reg2", m_syn_reg2, 0);
        check("nowen_reg1", m_syn_reg1, {64'h7, 64'h40});
        step(0, '0, '0, '0, 0, 1, 0);

        // Reset at level 6 discards everything; then a clean single push.
        for (int i = 0; i < 6; i++)
            step(1, 64'h5000 + 64'(i), 64'(400 + i), 64'(i), 1, 0, 0);
        check("prereset_level", level, 6);
        do_reset();
        step(1, 64'h8000_0000, 64'h1, 64'hDEAD, 1, 0, 0);
        check("post_rst_reg1", m_syn_reg1, {64'h1, 64'h8000_0000});
        check("post_rst_reg2", m_syn_reg2, {64'h0, 64'hDEAD});
        step(0, '0, '0, '0, 0, 1, 0);

        // Filtering instance: only rfwen=1 records enter, none count as drops.
        f_step(1, 64'd1, 0, 0);
        f_step(1, 64'd2, 1, 0);
        f_step(1, 64'd3, 0, 0);
        f_step(1, 64'd4, 1, 0);
        check("f_level", f_level, 2);
        check("f_drops", f_drop_cnt, 0);
        check("f_head1", f_m_syn_reg1, {64'd2, 64'h20});
        check("f_head1_rd", f_m_syn_reg2, {64'h0, 64'h102});
        f_step(0, '0, 0, 1);
        check("f_head2", f_m_syn_reg1, {64'd4, 64'h40});
        f_step(0, '0, 0, 1);
        check("f_empty", f_m_valid, 1'b0);
        for (int i = 10; i < 18; i++) f_step(1, 64'(i), 1, 0);
        check("f_full", f_s_ready, 1'b0);
        f_step(1, 64'd50, 0, 0);
        check("f_filtered_nodrop", f_drop_cnt, 0);
        check("f_filtered_noovf", f_overflow, 1'b0);
        f_step(1, 64'd51, 1, 0);
        check("f_real_drop", f_drop_cnt, 1);
        check("f_real_ovf", f_overflow, 1'b1);
        check("f_full_head", f_m_syn_reg1, {64'd10, 64'ha0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
